// File: rtl/port_arbiter.sv
// Round-robin arbiter feeding a single-entry output buffer for one router output link.
// Grants one requester per cycle whenever the buffer is empty or draining on the same edge.
module port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 5,
    parameter int CNTW       = 16,
    localparam int IDXW      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDXW-1:0]              last_grant,
    output logic [CNTW-1:0]              flit_count
);

    logic [IDXW-1:0]       r_ptr;
    logic [IDXW-1:0]       r_last_grant;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic [CNTW-1:0]       r_flit_count;

    logic [IDXW-1:0]       w_win;
    logic                  w_found;
    logic                  w_can_load;
    logic                  w_load;
    logic                  w_drain;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Requester index offset positions past base, wrapping at NUM_IN.
    function automatic logic [IDXW-1:0] rr_index(input logic [IDXW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_IN) sum = sum - NUM_IN;
        return sum[IDXW-1:0];
    endfunction

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        // Descending scan: the smallest offset from the pointer is written last and wins.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (in_valid[rr_index(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_index(r_ptr, k);
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_load     = w_found && w_can_load;
    assign w_drain    = r_out_valid && out_ready;

    always_comb begin
        w_sel_data = in_data[DATA_WIDTH-1:0];
        for (int i = 1; i < NUM_IN; i++) begin
            if (w_win == IDXW'(i)) w_sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Gated by rst so a handshake coinciding with reset assertion is never offered.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rst && w_load && (w_win == IDXW'(i))) in_ready[i] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_last_grant <= '0;
            r_ptr        <= '0;
        end else if (w_load) begin
            r_out_data   <= w_sel_data;
            r_out_valid  <= 1'b1;
            r_last_grant <= w_win;
            r_ptr        <= (w_win == IDXW'(NUM_IN - 1)) ? '0 : w_win + IDXW'(1);
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flit_count <= '0;
        end else if (w_drain && (r_flit_count != '1)) begin
            r_flit_count <= r_flit_count + CNTW'(1);
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign last_grant = r_last_grant;
    assign flit_count = r_flit_count;

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: directed scenarios plus random traffic,
// compared against a behavioural round-robin/buffer model.
module tb_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      last_grant;
    logic [15:0]     flit_count;

    logic [N-1:0]    s_in_ready;
    logic [DW-1:0]   s_out_data;
    logic            s_out_valid;
    logic [2:0]      s_last_grant;
    logic [3:0]      s_flit_count;

    logic [DW-1:0]   flits [N];

    // Behavioural model state
    bit              m_valid;
    logic [DW-1:0]   m_data;
    int              m_ptr;
    int              m_last;
    int              m_drains;

    int              n_assert;
    int              n_fail;

    port_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .CNTW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .last_grant (last_grant),
        .flit_count (flit_count)
    );

    port_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .CNTW(4)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .out_data   (s_out_data),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .last_grant (s_last_grant),
        .flit_count (s_flit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = flits[i];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (w >= 0 && (!m_valid || out_ready)) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] sat_min(input int v, input int lim);
        return (v > lim) ? 64'(lim) : 64'(v);
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_ptr    = 0;
        m_last   = 0;
        m_drains = 0;
    endtask

    // One clock cycle: inputs already driven after a negedge; returns at the next negedge.
    task automatic step();
        logic [N-1:0] er;
        int w;
        #1;
        er = model_ready();
        w  = model_winner();
        check("in_ready", in_ready, er);
        @(posedge clk);
        if (m_valid && out_ready) m_drains++;
        if (er != '0) begin
            m_data  = flits[w];
            m_valid = 1'b1;
            m_last  = w;
            m_ptr   = (w + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("last_grant", last_grant, m_last);
        check("flit_count", flit_count, sat_min(m_drains, 65535));
        check("flit_count_sat", s_flit_count, sat_min(m_drains, 15));
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_last_grant", last_grant, 0);
        check("rst_flit_count", flit_count, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) flits[i] = '0;
        apply_reset();

        // Single requester
        flits[2]  = 32'hA5A5_0002;
        in_valid  = 5'b00100;
        out_ready = 1'b1;
        #1;
        check("t1_ready", in_ready, 5'b00100);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'hA5A5_0002);
        check("t1_grant", last_grant, 2);
        in_valid = '0;
        step();
        check("t1_count", flit_count, 1);

        // Full contention from a fresh pointer
        apply_reset();
        for (int i = 0; i < N; i++) flits[i] = 32'h100 + 32'(i);
        in_valid  = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t2_seq", out_data, 32'h100 + 32'(k % N));
            check("t2_onehot", $onehot(in_ready), 1);
        end

        // Backpressure
        in_valid = '0;
        step();
        flits[0]  = 32'hDEAD_BEEF;
        in_valid  = 5'b00001;
        out_ready = 1'b0;
        step();
        check("t3_loaded", out_data, 32'hDEAD_BEEF);
        flits[1] = 32'h1111_1111;
        flits[3] = 32'h3333_3333;
        in_valid = 5'b01010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_hold_data", out_data, 32'hDEAD_BEEF);
            check("t3_hold_valid", out_valid, 1);
            check("t3_stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_ready", in_ready, 5'b00010);
        step();
        check("t3_drain_load", out_data, 32'h1111_1111);
        check("t3_grant1", last_grant, 1);
        in_valid = 5'b01000;
        step();
        check("t3_second", out_data, 32'h3333_3333);
        check("t3_grant3", last_grant, 3);

        // Pointer skip: pointer sits at 4 after serving requester 3
        in_valid = 5'b00010;
        step();
        check("t4_skip_grant", last_grant, 1);
        in_valid = 5'b00101;
        #1;
        check("t4_ready2", in_ready, 5'b00100);
        step();
        check("t4_grant2", last_grant, 2);

        // Async reset between edges with a buffered flit
        in_valid  = '1;
        out_ready = 1'b1;
        step();
        check("t5_pre_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 0);
        check("t5_async_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_prio0", in_ready, 5'b00001);
        step();
        check("t5_grant0", last_grant, 0);

        // Saturation of the narrow counter
        for (int k = 0; k < 22; k++) step();
        check("t6_sat15", s_flit_count, 15);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            in_valid  = N'($urandom);
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) flits[i] = $urandom;
            step();
        end
        check("t7_sat15", s_flit_count, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Round-robin output-port arbiter and single-entry output buffer for one router output of a mesh node. It shares one outgoing 32-bit link between up to NUM_IN requesters: Local, North, East, South and West input buffers. All sides use valid/ready handshakes. It sits between the node's input buffers and its dout/vout/rin output port, and keeps the link fully pipelined at one flit per cycle under contention.

## Interface
- DATA_WIDTH, 32, flit width in bits.
- NUM_IN, 5, number of requesters, legal range 2..8. Requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH] of in_data.
- IDXW, $clog2(NUM_IN), width of the grant index (derived, not overridden).
- CNTW, 16, width of the forwarded-flit counter.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  NUM_IN*DATA_WIDTH  packed requester flits.
- in_valid  in  NUM_IN  request per requester.
- in_ready  out  NUM_IN  one-hot accept; at most one bit high per cycle.
- out_data  out  DATA_WIDTH  buffered flit to the link (dout).
- out_valid  out  1  buffer holds a flit (vout).
- out_ready  in  1  downstream ready (rin).
- last_grant  out  IDXW  index of the most recently accepted requester.
- flit_count  out  CNTW  saturating count of flits delivered downstream.

## Operation
- State: output register (out_data, out_valid), round-robin pointer ptr (IDXW bits, 0..NUM_IN-1), last_grant, flit_count.
- can_load = !out_valid | out_ready.
- Winner: the first i with in_valid[i], scanning ptr, ptr+1, …, wrapping at NUM_IN back to 0. Computed combinationally.
- in_ready[winner] = can_load. All other in_ready bits are 0.
- All in_ready bits are 0 while rst is asserted and whenever no input is valid.
- A transfer on input i happens when in_valid[i] & in_ready[i]. On that edge:
  - out_data <= selected flit; out_valid <= 1;
  - last_grant <= i;
  - ptr <= (i == NUM_IN-1) ? 0 : i+1.
- A drain happens when out_valid & out_ready. If the drain occurs with no new transfer on the same edge, out_valid <= 0. out_data keeps its last value.
- A drain and a load on the same edge are legal: the new flit replaces the old one and out_valid stays 1. This gives full throughput.
- When no transfer occurs, ptr is unchanged. Priority only rotates past a requester that was actually served.
- flit_count increments on each drain and saturates at 2^CNTW-1 (no wrap).
- Fairness: with all NUM_IN requesters continuously valid and out_ready = 1, grants repeat 0,1,…,NUM_IN-1. A requester waits at most NUM_IN-1 transfers.
- Stall: while out_valid & !out_ready, out_data and out_valid are held stable and no in_ready is asserted. The requesters' in_valid and data must stay held (standard handshake rule; the arbiter does not enforce it).
- in_ready depends on in_valid, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.

## Timing
- Reset (async assert, values held until the first edge after deassert): out_valid = 0, out_data = 0, ptr = 0, last_grant = 0, flit_count = 0.
- Reset asserted mid-operation discards the buffered flit immediately. A requester whose handshake coincides with reset assertion is not accepted.
- Latency: a flit accepted on edge N appears on out_data/out_valid after edge N. That is one cycle, registered.
- Throughput: one flit per cycle when out_ready = 1.
- First request after reset: requester 0 wins if valid; otherwise the lowest valid index wins.

## Test plan
- Single requester: after reset, in_valid = 5'b00100 with data 0xA5A5_0002, out_ready = 1.
  - Expected: in_ready = 5'b00100 in the same cycle.
  - Next cycle: out_valid = 1, out_data = 0xA5A5_0002, last_grant = 2.
  - Following cycle: flit_count = 1.
- Full contention: all 5 valid, data = 0x100+i, out_ready = 1 for 10 cycles.
  - Expected: out_data sequence 0x100,0x101,0x102,0x103,0x104,0x100,… with no bubbles, and in_ready one-hot every cycle.
- Backpressure: buffer loaded with 0xDEAD_BEEF, out_ready = 0 for 4 cycles while inputs 1 and 3 are valid.
  - Expected: out_data held at 0xDEAD_BEEF, in_ready = 0.
  - Then raise out_ready: input 1 loads on that same edge (drain+load), then input 3 on the next edge.
- Pointer skip: ptr = 4 with only input 1 valid.
  - Expected: input 1 is granted and ptr becomes 2.
  - Then inputs 0 and 2 valid: input 2 wins first.
- Counter saturation with CNTW = 4: drain 20 flits.
  - Expected: flit_count stops at 15.
- Async reset mid-stream: assert rst low between edges while out_valid = 1.
  - Expected: out_valid = 0, out_data = 0 and in_ready = 0 immediately, with no clock edge required.
  - After release: requester 0 has priority.
